// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package data_memory_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    typedef logic [CNT_W-1:0] wait_cnt_t;

    // Index width needed to address `count` words; never narrower than one bit.
    function automatic int addr_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Synchronous single-port word storage with a registered read port.
module data_memory_array
    import data_memory_responder_pkg::*;
#(
    parameter int WORD_RANGE        = 8,
    parameter int MEMORY_WORD_COUNT = 256
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     we,
    input  logic                                     re,
    input  logic [addr_width(MEMORY_WORD_COUNT)-1:0] addr,
    input  logic [WORD_RANGE-1:0]                    wdata,
    output logic [WORD_RANGE-1:0]                    rdata
);

    logic [WORD_RANGE-1:0] mem [MEMORY_WORD_COUNT];

    // NOTE: storage has no reset so it maps onto RAM macros; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder: one load/store at a time, WAIT_STATES delay, then a held response.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int WORD_RANGE        = 8,
    parameter int MEMORY_WORD_COUNT = 256,
    parameter int WAIT_STATES       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [WORD_RANGE-1:0] req_addr,
    input  logic [WORD_RANGE-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_RANGE-1:0] rsp_rdata,
    output logic                  rsp_is_write,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int AW = addr_width(MEMORY_WORD_COUNT);

    state_t                state, state_nxt;
    wait_cnt_t             cnt, cnt_nxt;
    logic                  wr_q, err_q;
    logic [WORD_RANGE-1:0] addr_q;

    logic                  accept;
    logic                  in_range;
    logic                  mem_we, mem_re;
    logic [WORD_RANGE-1:0] mem_sel_addr;
    logic [WORD_RANGE-1:0] mem_rdata;

    assign in_range = 32'(req_addr) < MEMORY_WORD_COUNT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q   <= req_write;
                err_q  <= !in_range;
                addr_q <= req_addr;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        accept       = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_sel_addr = addr_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_is_write = 1'b0;
        rsp_err      = 1'b0;
        rsp_rdata    = '0;
        busy         = (state != IDLE);

        case (state)
            IDLE: begin
                req_ready    = 1'b1;
                mem_sel_addr = req_addr;
                if (req_valid) begin
                    accept = 1'b1;
                    // Stores commit at acceptance, so a reset during the wait cannot undo them.
                    mem_we = req_write && in_range;
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESPOND;
                        mem_re    = !req_write && in_range;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESPOND;
                    mem_re    = !wr_q && !err_q;
                end else begin
                    cnt_nxt = cnt - wait_cnt_t'(1);
                end
            end
            RESPOND: begin
                rsp_valid    = 1'b1;
                rsp_is_write = wr_q;
                rsp_err      = err_q;
                // Read data only means something for an in-range load.
                rsp_rdata    = (!wr_q && !err_q) ? mem_rdata : '0;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    data_memory_array #(
        .WORD_RANGE       (WORD_RANGE),
        .MEMORY_WORD_COUNT(MEMORY_WORD_COUNT)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_sel_addr[AW-1:0]),
        .wdata(req_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: four responder instances with different wait/size settings, scoreboard-checked.
module tb_data_memory_responder;

    localparam int N = 4;

    function automatic int w_of(input int i);
        case (i)
            0:       return 3;
            1:       return 2;
            2:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int count_of(input int i);
        return (i == 3) ? 128 : 256;
    endfunction

    typedef struct {
        logic       wr;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [N][256];
    int         n_tests = 0;
    int         n_fail  = 0;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst          [N];
    logic       req_valid    [N];
    logic       req_ready    [N];
    logic       req_write    [N];
    logic [7:0] req_addr     [N];
    logic [7:0] req_wdata    [N];
    logic       rsp_valid    [N];
    logic       rsp_ready    [N];
    logic [7:0] rsp_rdata    [N];
    logic       rsp_is_write [N];
    logic       rsp_err      [N];
    logic       busy         [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_memory_responder #(
            .WORD_RANGE       (8),
            .MEMORY_WORD_COUNT(count_of(g)),
            .WAIT_STATES      (w_of(g))
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_write   (req_write[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_rdata   (rsp_rdata[g]),
            .rsp_is_write(rsp_is_write[g]),
            .rsp_err     (rsp_err[g]),
            .busy        (busy[g])
        );
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; expectation pushed at drive time.
    task automatic do_txn(input int idx, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        exp_t got_e;
        int   lat;
        logic got;
        e.wr    = wr;
        e.err   = (int'(addr) >= count_of(idx));
        e.rdata = (wr || e.err) ? 8'h00 : model[idx][addr];
        if (wr && !e.err) model[idx][addr] = wdata;
        sb.push_back(e);

        @(negedge clk);
        rsp_ready[idx] = 1'b1;
        check($sformatf("u%0d req_ready idle", idx), 16'(req_ready[idx]), 16'h1);
        req_valid[idx] = 1'b1;
        req_write[idx] = wr;
        req_addr[idx]  = addr;
        req_wdata[idx] = wdata;
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;

        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[idx]) got = 1'b1;
        end
        check($sformatf("u%0d rsp arrives a%0h", idx, addr), 16'(got), 16'h1);
        if (got) begin
            got_e = sb.pop_front();
            check($sformatf("u%0d latency a%0h", idx, addr), 16'(lat), 16'(w_of(idx) + 1));
            check($sformatf("u%0d is_write a%0h", idx, addr), 16'(rsp_is_write[idx]), 16'(got_e.wr));
            check($sformatf("u%0d err a%0h", idx, addr), 16'(rsp_err[idx]), 16'(got_e.err));
            check($sformatf("u%0d rdata a%0h", idx, addr), 16'(rsp_rdata[idx]), 16'(got_e.rdata));
            @(negedge clk);
            check($sformatf("u%0d single rsp a%0h", idx, addr), 16'(rsp_valid[idx]), 16'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic got;
        logic seen;
        logic       r_wr;
        logic [7:0] r_addr;

        for (int i = 0; i < N; i++) begin
            rst[i]       = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 8'h00;
            req_wdata[i] = 8'h00;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        @(negedge clk);

        // Reset state on every instance
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d reset req_ready", i), 16'(req_ready[i]), 16'h1);
            check($sformatf("u%0d reset rsp_valid", i), 16'(rsp_valid[i]), 16'h0);
            check($sformatf("u%0d reset busy", i), 16'(busy[i]), 16'h0);
            check($sformatf("u%0d reset rsp_rdata", i), 16'(rsp_rdata[i]), 16'h0);
            check($sformatf("u%0d reset rsp_is_write", i), 16'(rsp_is_write[i]), 16'h0);
            check($sformatf("u%0d reset rsp_err", i), 16'(rsp_err[i]), 16'h0);
        end

        // Reset mid-WAIT (WAIT_STATES=3): store commits, response is aborted
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 8'h10;
        req_wdata[0] = 8'hA5;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("u0 busy in wait", 16'(busy[0]), 16'h1);
        rst[0] = 1'b1;
        #1;
        check("u0 async rst req_ready", 16'(req_ready[0]), 16'h1);
        check("u0 async rst rsp_valid", 16'(rsp_valid[0]), 16'h0);
        check("u0 async rst busy", 16'(busy[0]), 16'h0);
        @(negedge clk);
        rst[0] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[0]) seen = 1'b1;
        end
        check("u0 no rsp after reset", 16'(seen), 16'h0);
        model[0][8'h10] = 8'hA5;
        do_txn(0, 1'b0, 8'h10, 8'h00);

        // Load timing (WAIT_STATES=2)
        do_txn(1, 1'b1, 8'h10, 8'h33);
        do_txn(1, 1'b0, 8'h10, 8'h00);

        // Write-then-read (WAIT_STATES=0)
        do_txn(2, 1'b1, 8'h3F, 8'h5C);
        do_txn(2, 1'b0, 8'h3F, 8'h00);

        // Back-pressure (WAIT_STATES=1)
        do_txn(3, 1'b1, 8'h22, 8'h77);
        @(negedge clk);
        rsp_ready[3] = 1'b0;
        req_valid[3] = 1'b1;
        req_write[3] = 1'b0;
        req_addr[3]  = 8'h22;
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[3]) got = 1'b1;
        end
        check("u3 bp rsp arrives", 16'(got), 16'h1);
        check("u3 bp latency", 16'(lat), 16'h2);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                // Ignored store that would corrupt word 22 if accepted
                req_valid[3] = 1'b1;
                req_write[3] = 1'b1;
                req_addr[3]  = 8'h22;
                req_wdata[3] = 8'h00;
            end
            if (c == 2) req_valid[3] = 1'b0;
            check($sformatf("u3 bp rsp_valid c%0d", c), 16'(rsp_valid[3]), 16'h1);
            check($sformatf("u3 bp rdata c%0d", c), 16'(rsp_rdata[3]), 16'h77);
            check($sformatf("u3 bp req_ready c%0d", c), 16'(req_ready[3]), 16'h0);
            @(negedge clk);
        end
        rsp_ready[3] = 1'b1;
        @(negedge clk);
        check("u3 bp idle req_ready", 16'(req_ready[3]), 16'h1);
        check("u3 bp idle busy", 16'(busy[3]), 16'h0);
        check("u3 bp idle rsp_valid", 16'(rsp_valid[3]), 16'h0);
        do_txn(3, 1'b0, 8'h22, 8'h00);

        // Out of range (MEMORY_WORD_COUNT=128): C0 aliases 40 if truncated
        do_txn(3, 1'b1, 8'h40, 8'h11);
        do_txn(3, 1'b1, 8'hC0, 8'hFF);
        do_txn(3, 1'b0, 8'hC0, 8'h00);
        do_txn(3, 1'b0, 8'h40, 8'h00);

        // Throughput: preload a small window, then random mix
        for (int i = 0; i < 8; i++) do_txn(3, 1'b1, 8'(i), 8'(i * 17 + 3));
        for (int i = 0; i < 16; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 5) == 0) ? 8'(8'hC0 + $urandom_range(0, 63))
                                                 : 8'($urandom_range(0, 7));
            do_txn(3, r_wr, r_addr, 8'($urandom_range(0, 255)));
        end
        check("scoreboard drained", 16'(sb.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
